gcbp_subimage_reader: RTL and testbench
=======================================

Name: gcbp_subimage_reader

Overview:
- Read side of the GCBP sub-image BRAM, which the line generator fills one 128-bit line per sub-image row.
- Accepts a request of (sub-image, start row, row count) and issues sequential BRAM reads.
- Streams the returned lines out over a valid/ready interface to the downstream matching/correlation logic.
- Absorbs BRAM read latency and downstream backpressure with a small output FIFO.

Parameters:
- BRAM_DATA_WIDTH, 128, width of one GCBP line / BRAM word.
- ROW_BITS, 7, row address bits per sub-image; 2^ROW_BITS rows per sub-image.
- SUBIMAGE_BITS, 2, sub-image index bits; 4 horizontal sub-images.

Ports:
- i_clk  in  1  clock.
- i_resetn  in  1  synchronous, active-low reset.
- i_req_valid  in  1  request strobe.
- o_req_ready  out  1  high only in S_IDLE.
- i_req_subimage  in  SUBIMAGE_BITS  sub-image to read.
- i_req_row_start  in  ROW_BITS  first row.
- i_req_row_count  in  ROW_BITS+1  number of rows, 0..2^ROW_BITS.
- o_bram_en  out  1  BRAM read enable.
- o_bram_addr  out  SUBIMAGE_BITS+ROW_BITS  {subimage, row}.
- i_bram_rdata  in  BRAM_DATA_WIDTH  read data, valid exactly 1 cycle after o_bram_en.
- o_line_data  out  BRAM_DATA_WIDTH  FIFO head line.
- o_line_valid  out  1  FIFO non-empty.
- i_line_ready  in  1  downstream accepts.
- o_line_subimage  out  SUBIMAGE_BITS  sub-image tag of the head line.
- o_line_last  out  1  head line is the last line of the request.
- o_busy  out  1  request in progress (state != S_IDLE).

Behaviour:
- Reset values: all state registers and outputs are 0, o_req_ready is 1, FSM is in S_IDLE, FIFO is empty. Reset mid-request aborts the request, discards the in-flight read, and flushes the FIFO.
- States:
  - S_IDLE: on i_req_valid && o_req_ready, latch subimage, row_start and count into r_ regs. If count == 0, stay in S_IDLE and produce no output. Otherwise go to S_READ.
  - S_READ: in each cycle where (fifo_count + inflight) < 2, assert o_bram_en with addr {sub, row}, then row <= row+1 (modulo 2^ROW_BITS, so 127 wraps to 0) and remaining <= remaining-1. When the final read issues (remaining == 1), go to S_DRAIN.
  - S_DRAIN: wait until inflight == 0 and the FIFO is empty, then go to S_IDLE.
- inflight: a 1-bit register set on o_bram_en, cleared the next cycle. At that cycle, i_bram_rdata is pushed into the FIFO with the sub tag. The last flag is set when the pushed read was the request's final read.
- FIFO: 2 entries, first-word fall-through.
  - Pop when o_line_valid && i_line_ready.
  - Push and pop in the same cycle are allowed, with count unchanged.
  - The issue guard guarantees no push when full, so no overflow logic is needed.
- Throughput: 1 line/cycle with i_line_ready held high.
- Latency: request accept to first o_line_valid is 2 cycles (accept → read → push visible).
- o_line_data/subimage/last are stable while o_line_valid && !i_line_ready.
- i_req_* are ignored outside S_IDLE.
- A back-to-back request is accepted only after S_DRAIN completes.

Decomposition:
- Shared gcbp package holds:
  - BRAM_DATA_WIDTH, ROW_BITS, SUBIMAGE_BITS, C_NUM_HORI_SUBIMAGES (4);
  - the address-pack function {subimage, row};
  - the FSM state constants S_IDLE, S_READ, S_DRAIN (2 bits).
- One sub-module: gcbp_line_fifo, a 2-deep FWFT FIFO of {last, subimage, data} with push/pop/count.

Test Plan:
- Basic read: BRAM row r of sub 1 is preloaded with pattern {r repeated}. Request sub=1, start=10, count=4, ready=1 → addresses 0x08A..0x08D on consecutive cycles; 4 lines valid cycles 2–5 after accept, data rows 10–13, last only on the 4th; o_busy drops after drain.
- Wrap: request sub=3, start=126, count=4 → addresses 0x1FE, 0x1FF, 0x180, 0x181; data rows 126, 127, 0, 1.
- Backpressure: count=8, i_line_ready toggled 1-cycle-on/2-off → no line lost or duplicated, order rows 0–7 intact, at most 2 outstanding (FIFO + inflight), o_line_data stable while stalled.
- Edge counts: count=0 → no o_bram_en, no o_line_valid, o_req_ready stays 1. count=128 → exactly 128 lines, last on the 128th.
- Request during busy: a second i_req_valid pulse mid-read → ignored (o_req_ready=0), first request completes unchanged.
- Reset mid-request: i_resetn=0 for 1 cycle after 3 of 8 lines → next cycle o_line_valid=0, o_busy=0, o_req_ready=1; a new request works normally.

Source files
------------

// File: rtl/gcbp_pkg.sv
// Shared types and constants for the GCBP sub-image BRAM readers.
// Line geometry, FSM encoding and BRAM address packing.
package gcbp_pkg;

  localparam int BRAM_DATA_WIDTH      = 128;
  localparam int ROW_BITS             = 7;
  localparam int SUBIMAGE_BITS        = 2;
  localparam int C_NUM_HORI_SUBIMAGES = 4;
  localparam int ADDR_BITS            = SUBIMAGE_BITS + ROW_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                       last;
    logic [SUBIMAGE_BITS-1:0]   sub;
    logic [BRAM_DATA_WIDTH-1:0] data;
  } line_t;

  function automatic logic [ADDR_BITS-1:0] pack_addr(
    input logic [SUBIMAGE_BITS-1:0] sub,
    input logic [ROW_BITS-1:0]      row
  );
    return {sub, row};
  endfunction

endpackage

// File: rtl/gcbp_line_fifo.sv
// Two-entry first-word-fall-through line FIFO.
// An empty FIFO presents the incoming push directly at its head.
module gcbp_line_fifo
  import gcbp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        push_i,
  input  line_t       push_line_i,
  input  logic        pop_i,
  output line_t       head_o,
  output logic        valid_o,
  output logic [1:0]  count_o
);

  line_t      mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       empty;
  logic       do_wr;
  logic       do_rd;

  assign empty = (cnt_q == 2'd0);
  // Bypassed push popped in the same cycle never touches storage
  assign do_wr = push_i && !(empty && pop_i);
  assign do_rd = pop_i && !empty;

  assign valid_o = !empty || push_i;
  assign head_o  = empty ? push_line_i : mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_wr) begin
        mem_q[wr_q] <= push_line_i;
      end
      wr_q  <= wr_q ^ do_wr;
      rd_q  <= rd_q ^ do_rd;
      cnt_q <= cnt_q + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

endmodule

// File: rtl/gcbp_subimage_reader.sv
// Reads a run of GCBP lines from one sub-image and streams them
// downstream; read issue is throttled so the FIFO never overflows.
module gcbp_subimage_reader
  import gcbp_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [SUBIMAGE_BITS-1:0]   i_req_subimage,
  input  logic [ROW_BITS-1:0]        i_req_row_start,
  input  logic [ROW_BITS:0]          i_req_row_count,
  output logic                       o_bram_en,
  output logic [ADDR_BITS-1:0]       o_bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] i_bram_rdata,
  output logic [BRAM_DATA_WIDTH-1:0] o_line_data,
  output logic                       o_line_valid,
  input  logic                       i_line_ready,
  output logic [SUBIMAGE_BITS-1:0]   o_line_subimage,
  output logic                       o_line_last,
  output logic                       o_busy
);

  state_e                   state_q, state_d;
  logic [SUBIMAGE_BITS-1:0] sub_q, sub_d;
  logic [ROW_BITS-1:0]      row_q, row_d;
  logic [ROW_BITS:0]        rem_q, rem_d;
  logic                     infl_q, infl_d;
  logic                     infl_last_q, infl_last_d;

  logic       issue;
  logic [1:0] fifo_cnt;
  logic [1:0] occ;
  logic       pop;
  line_t      push_line;
  line_t      head;

  assign occ = fifo_cnt + {1'b0, infl_q};

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    row_d       = row_q;
    rem_d       = rem_q;
    issue       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          sub_d = i_req_subimage;
          row_d = i_req_row_start;
          rem_d = i_req_row_count;
          if (i_req_row_count != '0) begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        // FIFO slots plus the in-flight read bound the outstanding lines
        if (occ < 2'd2) begin
          issue = 1'b1;
          row_d = row_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == 1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!infl_q && fifo_cnt == 2'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    infl_d      = issue;
    infl_last_d = issue && (rem_q == 1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q     <= S_IDLE;
      sub_q       <= '0;
      row_q       <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      row_q       <= row_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_bram_en   = issue;
  assign o_bram_addr = pack_addr(sub_q, row_q);

  assign push_line.last = infl_last_q;
  assign push_line.sub  = sub_q;
  assign push_line.data = i_bram_rdata;

  assign pop = o_line_valid && i_line_ready;

  gcbp_line_fifo u_fifo (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .push_i      (infl_q),
    .push_line_i (push_line),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (o_line_valid),
    .count_o     (fifo_cnt)
  );

  assign o_line_data     = head.data;
  assign o_line_subimage = head.sub;
  assign o_line_last     = head.last;

endmodule

// File: tb/tb_gcbp_subimage_reader.sv
// Randomized scoreboard bench for gcbp_subimage_reader.
// A BRAM array and a row-list model produce the expected stream.
module tb_gcbp_subimage_reader;
  import gcbp_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_resetn = 1'b0;
  logic         i_req_valid = 1'b0;
  logic         o_req_ready;
  logic [1:0]   i_req_subimage = '0;
  logic [6:0]   i_req_row_start = '0;
  logic [7:0]   i_req_row_count = '0;
  logic         o_bram_en;
  logic [8:0]   o_bram_addr;
  logic [127:0] i_bram_rdata = '0;
  logic [127:0] o_line_data;
  logic         o_line_valid;
  logic         i_line_ready = 1'b1;
  logic [1:0]   o_line_subimage;
  logic         o_line_last;
  logic         o_busy;

  gcbp_subimage_reader dut (
    .i_clk           (i_clk),
    .i_resetn        (i_resetn),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_subimage  (i_req_subimage),
    .i_req_row_start (i_req_row_start),
    .i_req_row_count (i_req_row_count),
    .o_bram_en       (o_bram_en),
    .o_bram_addr     (o_bram_addr),
    .i_bram_rdata    (i_bram_rdata),
    .o_line_data     (o_line_data),
    .o_line_valid    (o_line_valid),
    .i_line_ready    (i_line_ready),
    .o_line_subimage (o_line_subimage),
    .o_line_last     (o_line_last),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [127:0] mem [512];
  always @(posedge i_clk) if (o_bram_en) i_bram_rdata <= mem[o_bram_addr];

  logic [8:0] exp_addr_q [$];
  line_t      exp_line_q [$];
  int vectors = 0;
  int miscompares = 0;
  int issued = 0;
  int popped = 0;
  int ready_mode = 0;
  int phase = 0;
  line_t held;
  bit held_v = 0;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0: i_line_ready = 1'b1;
      1: begin i_line_ready = (phase % 3 == 0); phase++; end
      default: i_line_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: addresses, stall stability, outstanding bound, line stream
  always @(negedge i_clk) begin
    if (i_resetn) begin
      if (o_bram_en) begin
        issued++;
        if (exp_addr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL bram_en: got unexpected read addr %0h", o_bram_addr);
        end else begin
          chk("bram_addr", 160'(o_bram_addr), 160'(exp_addr_q.pop_front()));
        end
        chk("outstanding_le2", 160'(issued - popped <= 2), 160'(1));
      end
      if (held_v) begin
        chk("stall_valid", 160'(o_line_valid), 160'(1));
        chk("stall_stable", 160'({o_line_last, o_line_subimage, o_line_data}),
            160'(held));
      end
      if (o_line_valid && i_line_ready) begin
        popped++;
        held_v = 0;
        if (exp_line_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL line: got unexpected line %0h", o_line_data);
        end else begin
          chk("line", 160'({o_line_last, o_line_subimage, o_line_data}),
              160'(exp_line_q.pop_front()));
        end
      end else if (o_line_valid) begin
        held_v = 1;
        held = '{last: o_line_last, sub: o_line_subimage, data: o_line_data};
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic do_req(input logic [1:0] sub, input logic [6:0] start,
                        input int cnt);
    int t = 0;
    logic [6:0] row;
    while (!o_req_ready && t < 2000) begin @(posedge i_clk); #1; t++; end
    chk("req_ready_before_req", 160'(o_req_ready), 160'(1));
    i_req_valid = 1'b1;
    i_req_subimage = sub;
    i_req_row_start = start;
    i_req_row_count = 8'(cnt);
    for (int i = 0; i < cnt; i++) begin
      row = 7'((int'(start) + i) % 128);
      exp_addr_q.push_back({sub, row});
      exp_line_q.push_back('{last: (i == cnt - 1), sub: sub,
                             data: mem[{sub, row}]});
    end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_subimage = 2'($urandom);
    i_req_row_start = 7'($urandom);
    i_req_row_count = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((o_busy || o_line_valid || exp_line_q.size() != 0) && t < 3000) begin
      @(posedge i_clk); #1; t++;
    end
    chk(name, 160'(t < 3000), 160'(1));
    chk({name, "_addrs_used"}, 160'(exp_addr_q.size()), 160'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int a = 0; a < 512; a++)
      mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 128; r++)
      mem[{2'd1, 7'(r)}] = {16{8'(r)}};

    repeat (3) @(posedge i_clk);
    #1;
    i_resetn = 1'b1;
    chk("rst_req_ready", 160'(o_req_ready), 160'(1));
    chk("rst_busy", 160'(o_busy), 160'(0));
    chk("rst_line_valid", 160'(o_line_valid), 160'(0));
    chk("rst_bram_en", 160'(o_bram_en), 160'(0));

    // Basic read with latency check
    ready_mode = 0;
    do_req(2'd1, 7'd10, 4);
    chk("lat_cycle1_valid", 160'(o_line_valid), 160'(0));
    chk("lat_busy", 160'(o_busy), 160'(1));
    @(posedge i_clk); #1;
    chk("lat_cycle2_valid", 160'(o_line_valid), 160'(1));
    wait_done("basic_done");

    do_req(2'd3, 7'd126, 4);
    wait_done("wrap_done");

    ready_mode = 1; phase = 0;
    do_req(2'd0, 7'd0, 8);
    wait_done("bp_done");

    // Zero-length request
    ready_mode = 0;
    do_req(2'd2, 7'd5, 0);
    chk("cnt0_req_ready", 160'(o_req_ready), 160'(1));
    chk("cnt0_busy", 160'(o_busy), 160'(0));
    repeat (4) begin
      @(posedge i_clk); #1;
      chk("cnt0_no_valid", 160'(o_line_valid), 160'(0));
    end

    ready_mode = 2;
    do_req(2'd2, 7'd0, 128);
    wait_done("cnt128_done");

    // Request while busy is ignored
    ready_mode = 1; phase = 0;
    do_req(2'd1, 7'd50, 8);
    repeat (3) @(posedge i_clk);
    #1;
    chk("busy_req_ready", 160'(o_req_ready), 160'(0));
    i_req_valid = 1'b1;
    i_req_subimage = 2'd3;
    i_req_row_start = 7'd0;
    i_req_row_count = 8'd5;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    wait_done("busy_done");

    // Reset after three of eight lines
    ready_mode = 0;
    begin
      int base;
      int t;
      base = popped;
      t = 0;
      do_req(2'd0, 7'd20, 8);
      while (popped < base + 3 && t < 200) begin @(posedge i_clk); #1; t++; end
      chk("rst_mid_reached", 160'(t < 200), 160'(1));
    end
    i_resetn = 1'b0;
    @(posedge i_clk); #1;
    i_resetn = 1'b1;
    exp_addr_q.delete();
    exp_line_q.delete();
    held_v = 0;
    issued = 0;
    popped = 0;
    chk("rst_mid_valid", 160'(o_line_valid), 160'(0));
    chk("rst_mid_busy", 160'(o_busy), 160'(0));
    chk("rst_mid_ready", 160'(o_req_ready), 160'(1));
    do_req(2'd1, 7'd100, 5);
    wait_done("post_rst_done");

    // Randomized requests
    repeat (20) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: cnt = 0;
          1: cnt = 1;
          default: cnt = 128;
        endcase
      end else begin
        cnt = int'($urandom_range(1, 20));
      end
      ready_mode = int'($urandom_range(0, 2));
      do_req(2'($urandom), 7'($urandom), cnt);
      wait_done("rand_done");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
